// File: rtl/ysyx_24080006_axil_sram_pkg.sv
// Shared types and helpers for the AXI4-Lite SRAM responder.
package ysyx_24080006_axil_sram_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned DLY_W  = 4;
  localparam int unsigned LFSR_W = 8;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

  // Channel FSM states shared by the read and write sides
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2
  } fsm_e;

  // AXI response codes produced by this responder
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    DECERR = 2'b11
  } axi_resp_e;

  // Latched write-data beat
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wbeat_t;

  // Expand byte strobes into a bit mask over the data word
  function automatic logic [DATA_W-1:0] wstrb_lut(input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < int'(STRB_W); i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/ysyx_24080006_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used as a response-delay source.
module ysyx_24080006_lfsr8
  import ysyx_24080006_axil_sram_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  output logic [LFSR_W-1:0] q
);

  // Shift left every cycle, feeding back the XOR of the tap bits
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= LFSR_SEED;
    end else begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

endmodule

// File: rtl/ysyx_24080006_axil_sram.sv
// AXI4-Lite SRAM responder with independent read and write channels.
// Define YSYX_24080006_RAND_DELAY_EN to draw per-transaction delays from an
// LFSR instead of the fixed LATENCY parameter.
module ysyx_24080006_axil_sram
  import ysyx_24080006_axil_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH_W   = 12,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned WORDS = 2**DEPTH_W;
  localparam logic [32:0] SPAN  = 33'(WORDS) << 2;

  logic [DATA_W-1:0] mem [WORDS];

  // Address decode: BASE_ADDR <= a < BASE_ADDR + 4*WORDS
  function automatic logic in_range(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return (a >= BASE_ADDR) && (off < SPAN);
  endfunction

  logic [DLY_W-1:0] rd_delay_c;
  logic [DLY_W-1:0] wr_delay_c;

`ifdef YSYX_24080006_RAND_DELAY_EN
  logic [LFSR_W-1:0] lfsr_q;

  ysyx_24080006_lfsr8 u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign rd_delay_c = lfsr_q[3:0];
  assign wr_delay_c = lfsr_q[7:4];
`else
  assign rd_delay_c = DLY_W'(LATENCY);
  assign wr_delay_c = DLY_W'(LATENCY);
`endif

  // ---------------- read channel ----------------
  fsm_e               rd_state;
  logic [DLY_W-1:0]   rd_cnt;
  logic [31:0]        rd_addr;
  logic               rd_hit_c;
  logic [DEPTH_W-1:0] rd_idx_c;

  assign rd_hit_c = in_range(rd_addr);
  assign rd_idx_c = rd_addr[DEPTH_W+1:2];

  // Read FSM: accept AR, count down the delay, capture data, hold R until accepted
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state <= IDLE;
      rd_cnt   <= '0;
      rd_addr  <= '0;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= OKAY;
    end else begin
      case (rd_state)
        IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            rd_addr  <= araddr;
            rd_cnt   <= rd_delay_c;
            arready  <= 1'b0;
            rd_state <= EXEC;
          end
        end
        EXEC: begin
          if (rd_cnt == '0) begin
            rdata    <= rd_hit_c ? mem[rd_idx_c] : '0;
            rresp    <= rd_hit_c ? OKAY : DECERR;
            rvalid   <= 1'b1;
            rd_state <= WAIT;
          end else begin
            rd_cnt <= rd_cnt - DLY_W'(1);
          end
        end
        WAIT: begin
          if (rready) begin
            rvalid   <= 1'b0;
            arready  <= 1'b1;
            rd_state <= IDLE;
          end
        end
        default: rd_state <= IDLE;
      endcase
    end
  end

  // ---------------- write channel ----------------
  fsm_e               wr_state;
  logic [DLY_W-1:0]   wr_cnt;
  logic [31:0]        wr_addr;
  wbeat_t             wr_beat;
  logic               aw_got;
  logic               w_got;
  logic               aw_fire_c;
  logic               w_fire_c;
  logic               aw_have_c;
  logic               w_have_c;
  logic               wr_hit_c;
  logic               wr_commit_c;
  logic [DEPTH_W-1:0] wr_idx_c;

  assign aw_fire_c   = awvalid && awready;
  assign w_fire_c    = wvalid && wready;
  assign aw_have_c   = aw_got || aw_fire_c;
  assign w_have_c    = w_got || w_fire_c;
  assign wr_hit_c    = in_range(wr_addr);
  assign wr_idx_c    = wr_addr[DEPTH_W+1:2];
  assign wr_commit_c = (wr_state == EXEC) && (wr_cnt == '0) && !reset;

  // Write FSM: gather AW and W in any order, count down, commit, hold B until accepted
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state <= IDLE;
      wr_cnt   <= '0;
      wr_addr  <= '0;
      wr_beat  <= '0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= OKAY;
    end else begin
      case (wr_state)
        IDLE: begin
          awready <= !aw_have_c;
          wready  <= !w_have_c;
          if (aw_fire_c) begin
            wr_addr <= awaddr;
            aw_got  <= 1'b1;
          end
          if (w_fire_c) begin
            wr_beat.data <= wdata;
            wr_beat.strb <= wstrb;
            w_got        <= 1'b1;
          end
          if (aw_have_c && w_have_c) begin
            wr_cnt   <= wr_delay_c;
            wr_state <= EXEC;
          end
        end
        EXEC: begin
          if (wr_cnt == '0) begin
            bresp    <= wr_hit_c ? OKAY : DECERR;
            bvalid   <= 1'b1;
            wr_state <= WAIT;
          end else begin
            wr_cnt <= wr_cnt - DLY_W'(1);
          end
        end
        WAIT: begin
          if (bready) begin
            bvalid   <= 1'b0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
            wr_state <= IDLE;
          end
        end
        default: wr_state <= IDLE;
      endcase
    end
  end

  // Array update: strobed byte merge; a same-cycle read capture sees the old word
  always_ff @(posedge clock) begin
    if (wr_commit_c && wr_hit_c) begin
      mem[wr_idx_c] <= (mem[wr_idx_c] & ~wstrb_lut(wr_beat.strb)) |
                       (wr_beat.data & wstrb_lut(wr_beat.strb));
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_axil_sram.sv
// Self-checking bench for ysyx_24080006_axil_sram against a word-map reference model.
module tb_ysyx_24080006_axil_sram;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SPAN = 32'h0000_4000;
  localparam int          LAT  = 1;

  logic        clock;
  logic        reset;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int cmp  = 0;
  int errs = 0;
  int cyc  = 0;

  logic [31:0] model [int unsigned];

  ysyx_24080006_axil_sram #(
    .BASE_ADDR (BASE),
    .DEPTH_W   (12),
    .LATENCY   (LAT)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic bit hit(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < SPAN);
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return hit(a) ? 2'b00 : 2'b11;
  endfunction

  // Byte-by-byte merge of a strobed write into the model word
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic bit lat_ok(input int l);
`ifdef YSYX_24080006_RAND_DELAY_EN
    return (l >= 2) && (l <= 17);
`else
    return l == 2 + LAT;
`endif
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    int unsigned k;
    if (!hit(a)) return;
    k = (a - BASE) >> 2;
    model[k] = merge(model.exists(k) ? model[k] : 32'h0, d, s);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int unsigned k;
    if (!hit(a)) return 32'h0;
    k = (a - BASE) >> 2;
    return model.exists(k) ? model[k] : 32'h0;
  endfunction

  // Drive one write; W is raised wlead cycles and AW awlead cycles after start
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int wlead, input int awlead,
                          output logic [1:0] resp, output int lat,
                          output int ready_extra, output bit timeout);
    int c0, t_hs, budget;
    bit aw_done, w_done;
    c0 = cyc; t_hs = cyc; budget = 0;
    aw_done = 0; w_done = 0; ready_extra = 0; timeout = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done)) begin
      awvalid = !aw_done && (cyc - c0 >= awlead);
      wvalid  = !w_done && (cyc - c0 >= wlead);
      if (w_done && wready) ready_extra++;
      if (aw_done && awready) ready_extra++;
      if (awvalid && awready) begin aw_done = 1; t_hs = cyc; end
      if (wvalid && wready) begin w_done = 1; t_hs = cyc; end
      step();
      budget++;
      if (budget > 100) begin timeout = 1; break; end
    end
    awvalid = 0; wvalid = 0; bready = 1;
    budget = 0;
    while (!bvalid && budget < 100) begin step(); budget++; end
    if (!bvalid) timeout = 1;
    lat = cyc - t_hs;
    resp = bresp;
    step();
    bready = 0;
  endtask

  // Drive one read, holding rready low for 'hold' cycles once rvalid appears
  task automatic do_read(input logic [31:0] a, input int hold,
                         output logic [31:0] data, output logic [1:0] resp,
                         output int lat, output bit stable, output bit timeout);
    int t_hs, budget;
    timeout = 0; stable = 1; budget = 0;
    araddr = a; arvalid = 1; rready = 0;
    while (!arready && budget < 100) begin step(); budget++; end
    t_hs = cyc;
    step();
    arvalid = 0;
    budget = 0;
    while (!rvalid && budget < 100) begin step(); budget++; end
    if (!rvalid || timeout) timeout = 1;
    lat = cyc - t_hs;
    data = rdata; resp = rresp;
    for (int k = 0; k < hold; k++) begin
      if (rdata !== data || rresp !== resp || rvalid !== 1'b1 || arready !== 1'b0) stable = 0;
      step();
    end
    rready = 1;
    step();
    rready = 0;
  endtask

  task automatic test_reset();
    reset = 1; arvalid = 1; araddr = BASE;
    for (int i = 0; i < 3; i++) begin
      step();
      cmp++;
      if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin
        errs++;
        $display("FAIL reset_hold: got ar/aw/w/rv/bv=%b required 00000",
                 {arready, awready, wready, rvalid, bvalid});
      end
    end
    arvalid = 0; reset = 0;
    step(); step();
    cmp++;
    if ({arready, awready, wready} !== 3'b111) begin
      errs++;
      $display("FAIL reset_ready: got ar/aw/w=%b required 111", {arready, awready, wready});
    end
    cmp++;
    if (rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin
      errs++;
      $display("FAIL reset_outputs: got rdata=%h rresp=%b bresp=%b required 0/00/00",
               rdata, rresp, bresp);
    end
  endtask

  task automatic test_full_word();
    logic [1:0] resp; logic [31:0] d; int lat, ex; bit to, st;
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, resp, lat, ex, to);
    model_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    cmp++;
    if (to || resp !== 2'b00 || !lat_ok(lat)) begin
      errs++;
      $display("FAIL full_write: got resp=%b lat=%0d to=%0d required 00 lat=2+delay", resp, lat, to);
    end
    do_read(32'h8000_0010, 0, d, resp, lat, st, to);
    cmp++;
    if (to || d !== 32'hDEAD_BEEF || resp !== 2'b00 || !lat_ok(lat)) begin
      errs++;
      $display("FAIL full_read: got %h/%b lat=%0d required DEADBEEF/00 lat=2+delay", d, resp, lat);
    end
  endtask

  task automatic test_strobes();
    logic [1:0] resp; logic [31:0] d; int lat, ex; bit to, st;
    logic [31:0] a;
    a = 32'h8000_0020;
    do_write(a, 32'h0, 4'hF, 0, 0, resp, lat, ex, to);
    model_write(a, 32'h0, 4'hF);
    do_write(a, 32'h00AB_0000, 4'b0100, 0, 0, resp, lat, ex, to);
    model_write(a, 32'h00AB_0000, 4'b0100);
    do_read(a, 0, d, resp, lat, st, to);
    cmp++;
    if (d !== 32'h00AB_0000) begin
      errs++; $display("FAIL strobe_0100: got %h required 00ab0000", d);
    end
    do_write(a, 32'h0000_1234, 4'b0011, 0, 0, resp, lat, ex, to);
    model_write(a, 32'h0000_1234, 4'b0011);
    do_read(a, 0, d, resp, lat, st, to);
    cmp++;
    if (d !== 32'h00AB_1234) begin
      errs++; $display("FAIL strobe_0011: got %h required 00ab1234", d);
    end
    do_write(a, 32'hFFFF_FFFF, 4'b0000, 0, 0, resp, lat, ex, to);
    cmp++;
    if (resp !== 2'b00) begin
      errs++; $display("FAIL strobe_0000_resp: got %b required 00", resp);
    end
    do_read(a, 0, d, resp, lat, st, to);
    cmp++;
    if (d !== 32'h00AB_1234) begin
      errs++; $display("FAIL strobe_0000_data: got %h required 00ab1234", d);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp; logic [31:0] d; int lat, ex, extra_b; bit to, st;
    do_write(32'h8000_0030, 32'hCAFE_F00D, 4'hF, 0, 2, resp, lat, ex, to);
    model_write(32'h8000_0030, 32'hCAFE_F00D, 4'hF);
    cmp++;
    if (to || ex != 0 || resp !== 2'b00) begin
      errs++;
      $display("FAIL w_first: got resp=%b extra_ready=%0d to=%0d required 00/0/0", resp, ex, to);
    end
    extra_b = 0;
    bready = 1;
    for (int i = 0; i < 8; i++) begin
      if (bvalid) extra_b++;
      step();
    end
    bready = 0;
    cmp++;
    if (extra_b != 0) begin
      errs++; $display("FAIL w_first_single_b: got %0d extra B cycles required 0", extra_b);
    end
    do_read(32'h8000_0030, 0, d, resp, lat, st, to);
    cmp++;
    if (d !== 32'hCAFE_F00D) begin
      errs++; $display("FAIL w_first_data: got %h required cafef00d", d);
    end
  endtask

  task automatic test_decode_backpressure();
    logic [1:0] resp; logic [31:0] d, a; int lat, ex; bit to, st;
    do_read(32'h7FFF_FFFC, 5, d, resp, lat, st, to);
    cmp++;
    if (to || resp !== 2'b11 || d !== 32'h0 || !st) begin
      errs++;
      $display("FAIL bp_decerr_read: got %h/%b stable=%0d required 00000000/11 stable=1", d, resp, st);
    end
    cmp++;
    if (arready !== 1'b1) begin
      errs++; $display("FAIL bp_arready_return: got %b required 1", arready);
    end
    // Word 0 must not be aliased by a write just past the top of the array
    do_write(BASE, 32'h1111_2222, 4'hF, 0, 0, resp, lat, ex, to);
    model_write(BASE, 32'h1111_2222, 4'hF);
    do_write(BASE + SPAN, 32'h9999_9999, 4'hF, 1, 0, resp, lat, ex, to);
    cmp++;
    if (resp !== 2'b11 || !lat_ok(lat)) begin
      errs++; $display("FAIL top_decerr_write: got %b lat=%0d required 11", resp, lat);
    end
    do_read(BASE, 0, d, resp, lat, st, to);
    cmp++;
    if (d !== 32'h1111_2222) begin
      errs++; $display("FAIL no_alias: got %h required 11112222", d);
    end
    a = BASE + SPAN - 32'd4;
    do_write(a, 32'h5A5A_A5A5, 4'hF, 0, 0, resp, lat, ex, to);
    model_write(a, 32'h5A5A_A5A5, 4'hF);
    do_read(a, 2, d, resp, lat, st, to);
    cmp++;
    if (d !== 32'h5A5A_A5A5 || resp !== 2'b00 || !st) begin
      errs++; $display("FAIL last_word: got %h/%b required 5a5aa5a5/00", d, resp);
    end
  endtask

`ifndef YSYX_24080006_RAND_DELAY_EN
  task automatic test_same_cycle();
    logic [1:0] rr, wr; logic [31:0] d; int rl, wl, ex; bit to1, to2, st;
    logic [31:0] a;
    a = 32'h8000_0040;
    d = model_read(a);
    fork
      do_read(a, 0, d, rr, rl, st, to1);
      do_write(a, 32'h7777_8888, 4'hF, 0, 0, wr, wl, ex, to2);
    join
    cmp++;
    if (d !== model_read(a)) begin
      errs++; $display("FAIL same_cycle_old: got %h required %h", d, model_read(a));
    end
    model_write(a, 32'h7777_8888, 4'hF);
    do_read(a, 0, d, rr, rl, st, to1);
    cmp++;
    if (d !== 32'h7777_8888) begin
      errs++; $display("FAIL same_cycle_new: got %h required 77778888", d);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [1:0] resp; logic [31:0] d, a, dat; logic [3:0] s; int lat, ex, hold; bit to, st;
    logic [31:0] oor [4];
    logic [3:0]  strbs [8];
    oor[0] = 32'h7FFF_FFFC; oor[1] = BASE + SPAN; oor[2] = 32'h0000_0100; oor[3] = 32'hFFFF_FFFC;
    strbs[0] = 4'b0001; strbs[1] = 4'b0010; strbs[2] = 4'b0100; strbs[3] = 4'b1000;
    strbs[4] = 4'b0011; strbs[5] = 4'b1100; strbs[6] = 4'b1111; strbs[7] = 4'b0000;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) a = oor[$urandom_range(0, 3)];
      else a = BASE + 32'h100 + 32'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 1) == 1) begin
        dat = $urandom;
        s = strbs[$urandom_range(0, 7)];
        do_write(a, dat, s, $urandom_range(0, 2), $urandom_range(0, 2), resp, lat, ex, to);
        model_write(a, dat, s);
        cmp++;
        if (to || resp !== exp_resp(a) || !lat_ok(lat)) begin
          errs++;
          $display("FAIL rand_write[%0d]: addr=%h got resp=%b lat=%0d required %b lat=2+delay",
                   i, a, resp, lat, exp_resp(a));
        end
      end else begin
        hold = $urandom_range(0, 3);
        do_read(a, hold, d, resp, lat, st, to);
        cmp++;
        if (to || d !== model_read(a) || resp !== exp_resp(a) || !lat_ok(lat) || !st) begin
          errs++;
          $display("FAIL rand_read[%0d]: addr=%h got %h/%b lat=%0d required %h/%b lat=2+delay",
                   i, a, d, resp, lat, model_read(a), exp_resp(a));
        end
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [1:0] resp; logic [31:0] d, a; int lat, ex, stray, budget; bit to, st;
    a = 32'h8000_0080;
    do_write(a, 32'h0BAD_F00D, 4'hF, 0, 0, resp, lat, ex, to);
    model_write(a, 32'h0BAD_F00D, 4'hF);
    budget = 0;
    while (!(arready && awready && wready) && budget < 20) begin step(); budget++; end
    araddr = a; arvalid = 1;
    awaddr = a; awvalid = 1; wdata = 32'hFFFF_0000; wstrb = 4'hF; wvalid = 1;
    rready = 1; bready = 1;
    cmp++;
    if (!(arready && awready && wready)) begin
      errs++; $display("FAIL mid_exec_idle: got ar/aw/w=%b required 111", {arready, awready, wready});
    end
    step();
    arvalid = 0; awvalid = 0; wvalid = 0;
    reset = 1;
    step(); step();
    reset = 0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      if (rvalid || bvalid) stray++;
      step();
    end
    rready = 0; bready = 0;
    cmp++;
    if (stray != 0) begin
      errs++; $display("FAIL mid_exec_stray: got %0d response cycles required 0", stray);
    end
    do_read(a, 0, d, resp, lat, st, to);
    cmp++;
    if (to || d !== 32'h0BAD_F00D) begin
      errs++; $display("FAIL mid_exec_no_commit: got %h required 0badf00d", d);
    end
  endtask

  initial begin
    reset = 1; araddr = '0; arvalid = 0; rready = 0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    test_reset();
    test_full_word();
    test_strobes();
    test_w_before_aw();
    test_decode_backpressure();
`ifndef YSYX_24080006_RAND_DELAY_EN
    test_same_cycle();
`endif
    test_back_to_back();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
